// File: rtl/timer_capture.sv
// Input-capture peripheral: times intervals between selected cap_in edges in prescaled ticks.
// Optional glitch filter enabled by defining TIMER_CAPTURE_FILTER_EN.
module timer_capture #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE   = 1,
    parameter int FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       edge_sel,
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_ovf,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t            state_r;
    logic              sync1_r;
    logic              sync2_r;
    logic              lvl_s;
    logic              prev_r;
    logic              en_prev_r;
    logic [1:0]        mode_r;
    logic [WIDTH-1:0]  cnt_r;
    logic [PC_W-1:0]   pc_r;
    logic              rise_s;
    logic              fall_s;
    logic              start_s;
    logic              stop_s;
    logic              pc_wrap_s;
    logic              cap_evt_s;
    logic              cap_sat_s;
    logic [WIDTH-1:0]  cap_val_s;

    // Two-flop synchronizer plus the previous-level register used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= cap_in;
            sync2_r <= sync1_r;
            prev_r  <= lvl_s;
        end
    end

`ifdef TIMER_CAPTURE_FILTER_EN
    localparam int FC_W = $clog2(FILTER_LEN);
    logic             filt_r;
    logic [FC_W-1:0]  fcnt_r;

    // Glitch filter: follow the synchronized level only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_r <= 1'b0;
            fcnt_r <= {FC_W{1'b0}};
        end else if (sync2_r == filt_r) begin
            fcnt_r <= {FC_W{1'b0}};
        end else if (fcnt_r == FC_W'(FILTER_LEN - 1)) begin
            filt_r <= sync2_r;
            fcnt_r <= {FC_W{1'b0}};
        end else begin
            fcnt_r <= fcnt_r + FC_W'(1);
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync2_r;
`endif

    // Edge decode, start/stop selection and the value a capture would report this cycle
    always_comb begin
        rise_s    = lvl_s & ~prev_r;
        fall_s    = ~lvl_s & prev_r;
        pc_wrap_s = (pc_r == PC_LAST);
        start_s   = 1'b0;
        stop_s    = 1'b0;
        case (mode_r)
            2'b00: begin start_s = rise_s; stop_s = rise_s; end
            2'b01: begin start_s = fall_s; stop_s = fall_s; end
            2'b10: begin start_s = rise_s; stop_s = fall_s; end
            2'b11: begin start_s = fall_s; stop_s = rise_s; end
            default: begin start_s = 1'b0; stop_s = 1'b0; end
        endcase
        cap_evt_s = enable & (state_r == ST_MEASURE) & stop_s;
        if (cnt_r == CNT_MAX) begin
            cap_sat_s = 1'b1;
            cap_val_s = CNT_MAX;
        end else begin
            cap_sat_s = 1'b0;
            cap_val_s = cnt_r + {{(WIDTH-1){1'b0}}, pc_wrap_s};
        end
    end

    // Measurement FSM with prescaler and saturating tick counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {WIDTH{1'b0}};
            pc_r      <= {PC_W{1'b0}};
            mode_r    <= 2'b00;
            en_prev_r <= 1'b0;
        end else begin
            en_prev_r <= enable;
            if (enable && !en_prev_r) begin
                mode_r <= edge_sel;
            end
            if (!enable) begin
                state_r <= ST_IDLE;
                cnt_r   <= {WIDTH{1'b0}};
                pc_r    <= {PC_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: state_r <= ST_ARMED;
                    ST_ARMED: begin
                        if (start_s) begin
                            state_r <= ST_MEASURE;
                            cnt_r   <= {WIDTH{1'b0}};
                            pc_r    <= {PC_W{1'b0}};
                        end
                    end
                    ST_MEASURE: begin
                        if (stop_s) begin
                            // period modes re-use the stop edge as the next start edge
                            cnt_r <= {WIDTH{1'b0}};
                            pc_r  <= {PC_W{1'b0}};
                            if (mode_r[1]) begin
                                state_r <= ST_ARMED;
                            end
                        end else if (pc_wrap_s) begin
                            pc_r <= {PC_W{1'b0}};
                            if (cnt_r != CNT_MAX) begin
                                cnt_r <= cnt_r + WIDTH'(1);
                            end
                        end else begin
                            pc_r <= pc_r + PC_W'(1);
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Result holding register, valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_data  <= {WIDTH{1'b0}};
            cap_ovf   <= 1'b0;
            cap_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (cap_evt_s && cap_valid && !cap_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (cap_evt_s && !(cap_valid && !cap_ready)) begin
                cap_data  <= cap_val_s;
                cap_ovf   <= cap_sat_s;
                cap_valid <= 1'b1;
            end else if (cap_valid && cap_ready) begin
                cap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
Input-capture peripheral, the measuring counterpart of the timer block. It samples an external pin and times the interval between selected edges in prescaled clock ticks. Results go out through a valid/ready holding register. It sits beside the timer in the Tang Nano 9k peripheral set, on the same clk/reset domain.

Parameters:
WIDTH, 16, bit width of tick counter and cap_data
PRESCALE, 1, clk cycles per tick (>=1)
FILTER_LEN, 4, stable-sample count for input filter (only with macro, >=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = capture running; 0 = idle
edge_sel  input  2  00 rise-to-rise period; 01 fall-to-fall period; 10 high width (rise-to-fall); 11 low width (fall-to-rise)
cap_in  input  1  asynchronous external signal
cap_data  output  WIDTH  captured tick count
cap_ovf  output  1  captured count saturated
cap_valid  output  1  cap_data/cap_ovf hold a result
cap_ready  input  1  consumer accepts result
overrun  output  1  sticky: a result was dropped
overrun_clr  input  1  clears overrun

Behaviour:
- Reset (async, any time, including mid-measurement):
  - all outputs 0; FSM to IDLE; counters, prescaler and synchronizer cleared.
  - After release, a fresh start edge is required.
- Input path:
  - 2-FF synchronizer, then edge detector (registered previous level).
  - Edge is flagged 3 clk after a cap_in transition. Fixed latency, so intervals are preserved.
- edge_sel is latched on the cycle enable goes 0->1. Changes while enabled are ignored.
- FSM:
  - IDLE: enable=1 -> ARMED.
  - ARMED: start edge -> MEASURE, cnt<=0, pc<=0.
  - MEASURE: stop edge -> capture event.
    - Period modes: counting restarts the same cycle (cnt<=0, pc<=0); stay in MEASURE.
    - Width modes: -> ARMED.
  - enable=0 in any state -> IDLE next cycle; cnt/pc cleared. A pending cap_valid result is retained.
- Counting:
  - Each MEASURE cycle, pc increments. When pc==PRESCALE-1, pc<=0 and cnt increments.
  - Captured value = cnt + (pc==PRESCALE-1). Equals floor(N/PRESCALE), where N = clk cycles between start- and stop-edge detection.
  - cnt saturates at 2^WIDTH-1. Once saturated, the capture reports all-ones with cap_ovf=1; otherwise cap_ovf=0.
- Output handshake:
  - Capture event loads cap_data/cap_ovf and sets cap_valid on the next clock edge.
  - Transfer occurs when cap_valid & cap_ready. cap_valid then drops unless a new capture loads in the same cycle.
  - Capture while cap_valid=1 and cap_ready=0: new result discarded, old held, overrun<=1.
  - Capture while cap_valid=1 and cap_ready=1: new result loaded, cap_valid stays 1, no overrun.
- overrun is sticky until overrun_clr=1, which clears it next edge. A simultaneous new overrun takes priority: it stays 1.

Optional Feature:
TIMER_CAPTURE_FILTER_EN
- Defined:
  - Glitch filter between synchronizer and edge detector. Filtered level changes only after FILTER_LEN consecutive equal synchronized samples.
  - Pulses shorter than FILTER_LEN clk are rejected.
  - Edge latency increases by FILTER_LEN.
  - Filter resets to 0.
- Undefined: filtered level = synchronized level; no extra logic or latency.

Test Plan:
1. PRESCALE=1, edge_sel=00, cap_ready=1, cap_in square wave period 20 clk -> after first rising edge, each subsequent rise yields cap_data=20, cap_ovf=0, one-cycle cap_valid pulses.
2. edge_sel=10, cap_in high 7 clk / low 13 clk -> cap_data=7 per pulse. edge_sel=11 gives 13. PRESCALE=4 with high 7 gives 1.
3. cap_ready=0, edge_sel=00, period 20, three rising edges:
   - cap_data stays 20, overrun=1.
   - overrun_clr pulse -> overrun=0.
   - cap_ready=1 -> cap_valid drops after one cycle.
4. WIDTH=8, edge_sel=00, period 300 clk -> cap_data=255, cap_ovf=1. Next period 50 -> cap_data=50, cap_ovf=0.
5. reset asserted for 2 clk during MEASURE with cap_valid=1:
   - outputs go 0 immediately.
   - first rising edge after release produces no capture.
   - second rising edge produces one.
6. edge_sel=10, 2-clk high glitch:
   - with TIMER_CAPTURE_FILTER_EN and FILTER_LEN=4: no cap_valid.
   - without the macro: cap_data=2.
